// File: rtl/fail_log_serializer_pkg.sv
// -----------------------------------------------------------------------------
// fail_log_serializer_pkg
// Shared definitions for the MBIST fail-log serializer:
//   - transmitter FSM state encoding
//   - serial frame line levels (start bit, stop/idle level)
//   - default fail-report address width
//   - divider width helper (a CLK_DIV of 1 still needs a 1-bit counter)
// -----------------------------------------------------------------------------
package fail_log_serializer_pkg;

  // Default width of a fail-report address and of each serial payload.
  localparam int FAIL_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;  // also the idle line level

  function automatic int div_width(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/fail_log_serializer_if.sv
// -----------------------------------------------------------------------------
// fail_log_serializer_if
// Groups the fail-report tap and the serial/status outputs of the serializer.
//   clear      : synchronous flush/abort pulse
//   fail_valid : one-cycle fail report strobe
//   fail_addr  : failing address, qualified by fail_valid
//   bist_done  : BIST completion indication
//   tx         : serial line, idle high
//   tx_busy    : a frame is being shifted
//   overflow   : sticky, a report was dropped
//   fail_count : saturating count of all fail reports
//   log_done   : BIST done and the log has fully drained
// Modports: slave = the serializer, master = the MBIST side / environment.
// -----------------------------------------------------------------------------
interface fail_log_serializer_if
  import fail_log_serializer_pkg::*;
#(
  parameter int ADDR_WIDTH = FAIL_ADDR_W,
  parameter int CNT_WIDTH  = 5
);
  logic                  clear;
  logic                  fail_valid;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic                  bist_done;
  logic                  tx;
  logic                  tx_busy;
  logic                  overflow;
  logic [CNT_WIDTH-1:0]  fail_count;
  logic                  log_done;

  modport slave (
    input  clear, fail_valid, fail_addr, bist_done,
    output tx, tx_busy, overflow, fail_count, log_done
  );

  modport master (
    output clear, fail_valid, fail_addr, bist_done,
    input  tx, tx_busy, overflow, fail_count, log_done
  );
endinterface

// File: rtl/fail_log_fifo.sv
// -----------------------------------------------------------------------------
// fail_log_fifo
// Small synchronous FIFO holding failing addresses until the serializer
// takes them. A push while full is accepted only if a pop happens in the same
// cycle, in which case occupancy is unchanged.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_flush    : synchronous empty (wins over push/pop)
//   i_push     : write request with i_wdata
//   i_pop      : read request; o_rdata is the current head
//   o_full     : occupancy == DEPTH
//   o_empty    : occupancy == 0
//   o_count    : occupancy, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module fail_log_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

  // NOTE: storage has no reset; entries are only read once the occupancy
  // counter says they were written, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: every sequential assignment is non-blocking so all registers update
  // from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of 2, so pointer wrap is the natural overflow.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: rtl/fail_log_serializer.sv
// -----------------------------------------------------------------------------
// fail_log_serializer
// Taps the MBIST fail-report stream, buffers failing addresses and sends each
// one off-chip as a UART-style frame: start bit (0), ADDR_WIDTH data bits LSB
// first, stop bit (1), every bit CLK_DIV clocks long. Also keeps a saturating
// fail count, a sticky overflow flag and a log-complete indication.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fail_log_serializer_if slave (inputs clear, fail_valid,
//                fail_addr, bist_done; outputs tx, tx_busy, overflow,
//                fail_count, log_done)
// -----------------------------------------------------------------------------
module fail_log_serializer
  import fail_log_serializer_pkg::*;
#(
  parameter int ADDR_WIDTH = FAIL_ADDR_W,
  parameter int DEPTH      = 4,
  parameter int CLK_DIV    = 4,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fail_log_serializer_if.slave  bus
);
  localparam int DIV_W = div_width(CLK_DIV);
  localparam int BIT_W = $clog2(ADDR_WIDTH + 1);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  tx_state_e             r_state;
  logic [ADDR_WIDTH-1:0] r_shift;
  logic [DIV_W-1:0]      r_div;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_tx;
  logic                  r_tx_busy;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_fail_count;
  logic                  r_done_seen;
  logic                  r_log_done;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_div_last;
  logic [ADDR_WIDTH-1:0] w_head;
  logic [OCC_W-1:0]      w_occupancy;

  assign w_push     = bus.fail_valid & ~bus.clear;
  assign w_pop      = (r_state == ST_IDLE) & ~w_empty & ~bus.clear;
  assign w_div_last = (r_div == DIV_LAST);

  fail_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (bus.fail_addr),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_occupancy)
  );

  // Fail count sees every strobe, accepted or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_count <= '0;
      r_overflow   <= 1'b0;
    end else if (bus.clear) begin
      r_fail_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (bus.fail_valid && (r_fail_count != CNT_MAX))
        r_fail_count <= r_fail_count + CNT_WIDTH'(1);
      // Full is only a refusal when the transmitter is not freeing a slot.
      if (w_push && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_div       <= '0;
      r_bit_cnt   <= '0;
      r_tx        <= STOP_BIT;
      r_tx_busy   <= 1'b0;
      r_done_seen <= 1'b0;
      r_log_done  <= 1'b0;
    end else if (bus.clear) begin
      r_state     <= ST_IDLE;
      r_div       <= '0;
      r_bit_cnt   <= '0;
      r_tx        <= STOP_BIT;
      r_tx_busy   <= 1'b0;
      r_done_seen <= 1'b0;
      r_log_done  <= 1'b0;
    end else begin
      // Line outputs are registered from the current state, so they trail the
      // state by one cycle; this gives the two-cycle report-to-start latency.
      unique case (r_state)
        ST_IDLE:  begin r_tx <= STOP_BIT;   r_tx_busy <= 1'b0; end
        ST_START: begin r_tx <= START_BIT;  r_tx_busy <= 1'b1; end
        ST_DATA:  begin r_tx <= r_shift[0]; r_tx_busy <= 1'b1; end
        default:  begin r_tx <= STOP_BIT;   r_tx_busy <= 1'b1; end
      endcase

      r_log_done <= r_done_seen && (w_occupancy == '0) && (r_state == ST_IDLE);
      if (bus.bist_done) r_done_seen <= 1'b1;

      unique case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift   <= w_head;
            r_bit_cnt <= '0;
            r_div     <= '0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_div_last) begin
            r_div   <= '0;
            r_state <= ST_DATA;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_div_last) begin
            r_div     <= '0;
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) r_state <= ST_STOP;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: begin
          if (w_div_last) begin
            r_div   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.tx         = r_tx;
  assign bus.tx_busy    = r_tx_busy;
  assign bus.overflow   = r_overflow;
  assign bus.fail_count = r_fail_count;
  assign bus.log_done   = r_log_done;
endmodule

// File: tb/tb_fail_log_serializer.sv
// -----------------------------------------------------------------------------
// tb_fail_log_serializer
// Drives fail reports, bist_done and clear into fail_log_serializer. A
// behavioural model (address queue plus a "transmitter busy for N cycles"
// timer) predicts the status outputs each cycle and queues every frame that
// should appear on tx, with its expected start cycle. A separate monitor
// decodes frames from tx/tx_busy and compares them against that queue.
// -----------------------------------------------------------------------------
module tb_fail_log_serializer;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int CD    = 4;
  localparam int CW    = 5;
  localparam int FRAME = (AW + 2) * CD;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct {
    logic [AW-1:0] addr;
    int            start;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;

  fail_log_serializer_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) ifc ();

  fail_log_serializer #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .CLK_DIV    (CD),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_frames = 0;
  int abort_gen = 0;

  // Reference model state.
  exp_t          sb_q[$];
  logic [AW-1:0] m_fifo[$];
  int            m_busy;
  int            m_count;
  bit            m_ovf;
  bit            m_done_seen;
  bit            m_log_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected line level for each clock of a frame carrying a.
  function automatic logic [FRAME-1:0] frame_wave(input logic [AW-1:0] a);
    logic [FRAME-1:0] w;
    for (int c = 0; c < FRAME; c++) begin
      int b;
      b = c / CD;
      if (b == 0)       w[c] = 1'b0;
      else if (b <= AW) w[c] = a[b-1];
      else              w[c] = 1'b1;
    end
    return w;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    sb_q.delete();
    m_busy      = 0;
    m_count     = 0;
    m_ovf       = 0;
    m_done_seen = 0;
    m_log_done  = 0;
    abort_gen++;
  endtask

  // Predict the effect of the coming clock edge given the inputs now driven.
  task automatic model_step(input bit fv, input logic [AW-1:0] fa, input bit bd, input bit clr);
    bit idle, empty;
    if (!rst_n || clr) begin
      model_reset();
      return;
    end
    idle  = (m_busy == 0);
    empty = (m_fifo.size() == 0);
    m_log_done = m_done_seen && empty && idle;
    if (bd) m_done_seen = 1;
    if (idle && !empty) begin
      exp_t e;
      e.addr  = m_fifo.pop_front();
      e.start = cyc + 2;        // popped at edge cyc+1, line falls after cyc+2
      sb_q.push_back(e);
      m_busy = FRAME;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    if (fv) begin
      if (m_count < CMAX) m_count++;
      if (m_fifo.size() < DEPTH) m_fifo.push_back(fa);
      else                       m_ovf = 1;
    end
  endtask

  // One clock: check the state left by the previous edge, then drive inputs.
  task automatic step(input bit fv, input logic [AW-1:0] fa, input bit bd, input bit clr);
    @(negedge clk);
    #1;
    check("fail_count", ifc.fail_count, m_count);
    check("overflow",   ifc.overflow,   m_ovf);
    check("log_done",   ifc.log_done,   m_log_done);
    ifc.fail_valid = fv;
    ifc.fail_addr  = fa;
    ifc.bist_done  = bd;
    ifc.clear      = clr;
    model_step(fv, fa, bd, clr);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0);
  endtask

  // Frame monitor / scoreboard consumer.
  initial begin : monitor
    bit last_busy;
    last_busy = 0;
    forever begin
      @(negedge clk);
      if (rst_n && ifc.tx_busy && (ifc.tx == 1'b0)) begin
        logic [FRAME-1:0] got;
        exp_t e;
        bit   have, aborted;
        int   gen;
        gen = abort_gen;
        check("busy_rise", last_busy, 0);
        have = (sb_q.size() != 0);
        if (have) begin
          e = sb_q.pop_front();
          check("frame_start", cyc, e.start);
        end else begin
          check("unexpected_frame", 1, 0);
        end
        got = '0;
        aborted = 0;
        for (int c = 1; c < FRAME; c++) begin
          @(negedge clk);
          if (!rst_n || !ifc.tx_busy) begin
            aborted = 1;
            break;
          end
          got[c] = ifc.tx;
        end
        if (aborted) begin
          if (gen == abort_gen) check("frame_truncated", 1, 0);
          last_busy = 0;
        end else begin
          if (have) begin
            check("frame_bits", got, frame_wave(e.addr));
            n_frames++;
          end
          @(negedge clk);
          check("busy_fall", ifc.tx_busy, 0);
          last_busy = ifc.tx_busy;
        end
      end else begin
        last_busy = ifc.tx_busy;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int guard;
    rst_n = 1'b0;
    ifc.clear = 0; ifc.fail_valid = 0; ifc.fail_addr = '0; ifc.bist_done = 0;
    model_reset();
    idle_cycles(3);
    check("rst_tx",   ifc.tx, 1);
    check("rst_busy", ifc.tx_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);

    // Single report, 0xA5.
    step(1, 8'hA5, 0, 0);
    idle_cycles(50);

    // Six back-to-back reports; the sixth is dropped.
    for (int i = 1; i <= 6; i++) step(1, AW'(i), 0, 0);
    idle_cycles(5 * (FRAME + 1) + 10);

    // Fill the FIFO, then report exactly on the cycle the transmitter pops.
    step(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, AW'(8'h11 + i), 0, 0);
    guard = 0;
    while (!(m_busy == 0 && m_fifo.size() == DEPTH) && guard < 200) begin
      step(0, '0, 0, 0);
      guard++;
    end
    check("full_pop_found", guard < 200, 1);
    step(1, 8'h16, 0, 0);
    step(0, '0, 0, 0);
    check("full_push_pop_ovf", ifc.overflow, 0);
    idle_cycles(5 * (FRAME + 1) + 10);

    // bist_done with entries pending, then a late report.
    step(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, AW'(8'h21 + i), 0, 0);
    step(0, '0, 1, 0);
    idle_cycles(3 * (FRAME + 1) + 5);
    check("log_done_set", ifc.log_done, 1);
    step(1, 8'h3C, 0, 0);
    idle_cycles(FRAME + 6);

    // clear mid-DATA of 0x7E with three entries queued.
    step(0, '0, 0, 1);
    step(1, 8'h7E, 0, 0);
    for (int i = 0; i < 3; i++) step(1, AW'(8'h41 + i), 0, 0);
    idle_cycles(10);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    check("clr_tx",   ifc.tx, 1);
    check("clr_busy", ifc.tx_busy, 0);
    idle_cycles(2 * FRAME);

    // fail_valid and bist_done coincident with clear are ignored.
    step(1, 8'h99, 1, 1);
    idle_cycles(FRAME);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      bit fv, bd, clr;
      fv  = ($urandom_range(0, 5) == 0);
      bd  = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 299) == 0);
      step(fv, AW'($urandom_range(0, 255)), bd, clr);
    end
    idle_cycles(DEPTH * (FRAME + 1) + 10);

    // Saturation, then asynchronous reset mid-frame.
    step(0, '0, 0, 1);
    for (int i = 0; i < 40; i++) step(1, AW'($urandom_range(0, 255)), 0, 0);
    step(0, '0, 0, 0);
    check("sat_count", ifc.fail_count, CMAX);
    idle_cycles(20);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx",       ifc.tx, 1);
    check("arst_busy",     ifc.tx_busy, 0);
    check("arst_overflow", ifc.overflow, 0);
    check("arst_count",    ifc.fail_count, 0);
    check("arst_log_done", ifc.log_done, 0);
    model_reset();
    idle_cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(5);
    step(1, 8'h5A, 0, 0);
    idle_cycles(FRAME + 10);

    check("sb_drained", sb_q.size(), 0);
    check("frames_seen", n_frames >= 15, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fail_log_serializer.md
Name: fail_log_serializer

Overview:
- Sits beside the MBIST/MBISR pair in the top-level integration and taps the MBIST fail-report stream (fail_valid/fail_addr).
- Buffers each reported failing address in a small FIFO.
- Transmits each address off-chip on a single UART-style serial line, the only path out through the limited pin budget.
- Also provides a saturating fail count, a sticky overflow flag, and a log-complete indication once BIST is done and the log has drained.

Parameters:
ADDR_WIDTH, 8, width of fail_addr and of each serial data payload
DEPTH, 4, FIFO entries; power of 2, minimum 2
CLK_DIV, 4, clk cycles per serial bit; minimum 1
CNT_WIDTH, 5, width of fail_count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush/abort pulse, asserted at the start of each BIST run
fail_valid  input  1  one-cycle fail report strobe from the MBIST controller
fail_addr  input  ADDR_WIDTH  failing address, qualified by fail_valid
bist_done  input  1  BIST completion level/pulse from the MBIST controller
tx  output  1  serial output; idle high
tx_busy  output  1  high while a frame is being shifted (START/DATA/STOP)
overflow  output  1  sticky; a report was dropped because the FIFO was full
fail_count  output  CNT_WIDTH  saturating count of all fail_valid strobes, including dropped ones
log_done  output  1  BIST is done and every buffered entry has been transmitted

Behaviour:
Reset (rst_n low, asynchronous):
- tx=1, tx_busy=0, overflow=0, fail_count=0, log_done=0.
- FIFO is empty and the FSM is in IDLE.
- Deassertion takes effect on the next clk edge.

FIFO:
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy counter is log2(DEPTH)+1 bits.
- Push on fail_valid when occupancy < DEPTH, or when a pop occurs in the same cycle (full + push + pop is accepted, and occupancy is unchanged).
- A fail_valid that is refused sets overflow. The entry is discarded and stored entries are untouched.

fail_count:
- Increments on every fail_valid.
- Saturates at 2^CNT_WIDTH-1 and never wraps.

TX FSM, states IDLE, START, DATA, STOP:
- IDLE:
  - tx=1, tx_busy=0.
  - If the FIFO is non-empty: pop the head into the shift register, clear the bit counter and divider, and go to START.
- START:
  - tx=0 for CLK_DIV cycles, then go to DATA.
- DATA:
  - tx = shift register bit 0 (LSB first).
  - Every CLK_DIV cycles, shift right and increment the bit counter.
  - After ADDR_WIDTH bits, go to STOP.
- STOP:
  - tx=1 for CLK_DIV cycles, then go to IDLE.
- Frame length is (ADDR_WIDTH+2)*CLK_DIV cycles; with defaults, 40 cycles.
- Back-to-back frames: IDLE lasts exactly one cycle between frames when the FIFO is non-empty.

tx_busy:
- High in START, DATA and STOP.

Latency:
- fail_valid sampled at edge N with FIFO empty and FSM in IDLE.
- Entry is present after N. Pop happens at N+1. tx falls after edge N+2.
- tx and tx_busy are registered outputs.

log_done:
- An internal sticky flag done_seen is set when bist_done=1.
- log_done = done_seen AND FIFO empty AND FSM in IDLE, registered.
- Remains high until clear or reset.
- A fail_valid arriving after done_seen is still logged, and log_done drops until that entry has drained.

clear (synchronous, highest priority below reset):
- Empties the FIFO and zeroes fail_count.
- Clears overflow, done_seen and log_done.
- Aborts any frame: FSM to IDLE, tx=1 on the next cycle.
- A fail_valid in the same cycle as clear is ignored.
- A bist_done in the same cycle as clear is ignored.

Arithmetic:
- All counters are unsigned.
- The divider counts 0..CLK_DIV-1.
- The bit counter is clog2(ADDR_WIDTH+1) bits.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3);
  - frame constants (start bit 0, stop/idle level 1);
  - the fail-report field width tied to ADDR_WIDTH.
- One natural sub-module: fail_log_fifo (parameterised DEPTH/width, push/pop/full/empty/occupancy, overflow-safe simultaneous push+pop).
- The serializer FSM, divider, counters and log_done logic stay in the parent.

Test Plan:
- Reset then single fail_valid with fail_addr=0xA5, CLK_DIV=4 -> tx low 2 cycles later for 4 cycles; bits 1,0,1,0,0,1,0,1 for 4 cycles each; stop high; tx_busy high for exactly 40 cycles; fail_count=1.
- 6 fail_valid on consecutive cycles (0x01..0x06), DEPTH=4 -> 0x01 popped immediately, 0x02–0x05 stored, 0x06 dropped; overflow=1; fail_count=6; five frames transmitted in order 0x01..0x05 with 1-cycle IDLE gaps.
- Full FIFO with fail_valid coinciding with an IDLE pop -> push accepted, overflow stays 0, occupancy unchanged at 4.
- bist_done pulse while 2 entries pending -> log_done stays 0 until the second frame's STOP ends, then 1 the following cycle; a later fail_valid=0x3C drops log_done until 0x3C has been sent.
- clear asserted mid-DATA of frame 0x7E with 3 entries queued -> tx=1 and tx_busy=0 the next cycle; FIFO empty; fail_count=0; overflow=0; no further frames.
- 40 fail_valid strobes, CNT_WIDTH=5 -> fail_count saturates at 31; rst_n asserted asynchronously mid-frame -> all outputs return to reset values immediately without a clk edge.
